rv32_uart: RTL

//  Memory-mapped UART that acts as a responder on the data memory bus, driven by the memory stage.

---
 rtl/rv32_uart_if.sv | 20 ++
 rtl/rv32_uart.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rv32_uart_if.sv
// rv32_uart_if: data-memory bus between the memory stage (master) and the UART responder (slave)
interface rv32_uart_if;
  logic        stall_in;
  logic        sel_in;
  logic        read_in;
  logic        write_in;
  logic [31:0] address_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;
  logic        fault_out;
  modport master (
    output stall_in, sel_in, read_in, write_in, address_in, write_mask_in, write_value_in,
    input  read_value_out, fault_out
  );
  modport slave (
    input  stall_in, sel_in, read_in, write_in, address_in, write_mask_in, write_value_in,
    output read_value_out, fault_out
  );
endinterface

// File: rtl/rv32_uart.sv
// rv32_uart: zero-wait-state memory-mapped 8N1 UART with TX FIFO; define UART_RX_EN to build the receiver
module rv32_uart #(
  parameter int          TX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd103
) (
  input  logic       clk,
  input  logic       reset,
  rv32_uart_if.slave bus,
  output logic       tx_out,
  input  logic       rx_in
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0]   FULL    = TX_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  tx_state_t     tx_state_q, tx_state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    fifo_q [TX_DEPTH];
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   div_q, div_d, baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          tx_q, tx_d;
  logic [1:0]    rsel;
  logic [31:0]   rd_value;
  logic          acc, fault, wr_ok, push, pop, empty, tx_full, tx_idle, bit_end, div_wr;
  logic          rx_valid, rx_overrun;
  logic [7:0]    rx_data;
  logic          unused;
  assign rsel    = bus.address_in[3:2];
  assign acc     = bus.sel_in && (bus.read_in || bus.write_in);
  assign empty   = count_q == '0;
  assign tx_full = count_q == FULL;
  assign tx_idle = tx_state_q == IDLE && empty;
  assign bit_end = baud_q == 16'd0;
  assign fault   = acc && (bus.address_in[1:0] != 2'd0 || rsel == 2'd3 ||
                   (bus.write_in && rsel == 2'd0 && bus.write_mask_in[0] && tx_full));
  assign wr_ok   = acc && !fault && !bus.stall_in && bus.write_in;
  assign push    = wr_ok && rsel == 2'd0 && bus.write_mask_in[0];
  assign div_wr  = wr_ok && rsel == 2'd2;
  assign rd_value = rsel == 2'd0 ? {23'd0, rx_valid, rx_data} :
                    rsel == 2'd1 ? {28'd0, rx_overrun, rx_valid, tx_full, tx_idle} : {16'd0, div_q};
  assign bus.read_value_out = bus.sel_in && bus.read_in && !fault ? rd_value : 32'd0;
  assign bus.fault_out = fault;
  assign tx_out = tx_q;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = push && !pop ? count_q + CNT_ONE : pop && !push ? count_q - CNT_ONE : count_q;
    div_d    = {div_wr && bus.write_mask_in[1] ? bus.write_value_in[15:8] : div_q[15:8],
                div_wr && bus.write_mask_in[0] ? bus.write_value_in[7:0] : div_q[7:0]};
  end
  // tx_q lags the FSM by one edge, so a push at edge N drives the start bit from N+2
  always_comb begin
    tx_state_d = tx_state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    baud_d     = tx_state_q == IDLE || bit_end ? div_q : baud_q - 16'd1;
    pop        = 1'b0;
    if (tx_state_q == IDLE || (tx_state_q == STOP && bit_end)) begin
      tx_state_d = empty ? IDLE : START;
      pop        = !empty;
      shift_d    = empty ? shift_q : fifo_q[rd_ptr_q];
    end else if (bit_end && tx_state_q == START) tx_state_d = DATA;
    else if (bit_end && tx_state_q == DATA) begin
      shift_d    = {1'b0, shift_q[7:1]};
      bit_d      = bit_q + 3'd1;
      tx_state_d = bit_q == 3'd7 ? STOP : DATA;
    end
    tx_d = tx_state_q == START ? 1'b0 : tx_state_q == DATA ? shift_q[0] : 1'b1;
  end
  always_ff @(posedge clk) if (push) fifo_q[wr_ptr_q] <= bus.write_value_in[7:0];
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      div_q      <= DIV_RESET;
      baud_q     <= '0;
      bit_q      <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
    end
  end
`ifdef UART_RX_EN
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  rx_state_t   rx_state_q, rx_state_d;
  logic [2:0]  rx_sync_q, rx_sync_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, rx_done, clr_valid, clr_over, keep;
  assign clr_valid = wr_ok && rsel == 2'd1 && bus.write_mask_in[0] && bus.write_value_in[2];
  assign clr_over  = wr_ok && rsel == 2'd1 && bus.write_mask_in[0] && bus.write_value_in[3];
  assign keep      = rx_valid_q && !clr_valid;
  // rx_sync_q[1] is the synchronised line, rx_sync_q[2] its previous value for edge detection
  always_comb begin
    rx_sync_d  = {rx_sync_q[1:0], rx_in};
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q - 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    if (rx_state_q == R_IDLE) begin
      rx_state_d = rx_sync_q[2] && !rx_sync_q[1] ? R_START : R_IDLE;
      rx_cnt_d   = div_q == 16'd0 ? 16'd0 : (div_q - 16'd1) >> 1;
    end else if (rx_cnt_q == 16'd0) begin
      rx_cnt_d = div_q;
      if (rx_state_q == R_START) rx_state_d = rx_sync_q[1] ? R_IDLE : R_DATA;
      else if (rx_state_q == R_DATA) begin
        rx_shift_d = {rx_sync_q[1], rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        rx_state_d = rx_bit_q == 3'd7 ? R_STOP : R_DATA;
      end else begin
        rx_state_d = R_IDLE;
        rx_done    = rx_sync_q[1];
      end
    end
    rx_valid_d   = keep || rx_done;
    rx_overrun_d = (rx_overrun_q && !clr_over) || (rx_done && keep);
    rx_data_d    = rx_done && !keep ? rx_shift_q : rx_data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state_q   <= R_IDLE;
      rx_sync_q    <= '1;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_sync_q    <= rx_sync_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign rx_data    = rx_data_q;
  assign unused = ^{bus.address_in[31:4], bus.write_mask_in[3:2], bus.write_value_in[31:16]};
`else
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_data    = 8'd0;
  assign unused = ^{rx_in, bus.address_in[31:4], bus.write_mask_in[3:2], bus.write_value_in[31:16]};
`endif
endmodule
